// File: rtl/ram_slot_seq_if.sv
// ram_slot_seq_if: slot requests in, DRAM strobes and acknowledges out.
// master drives requests, slave is the sequencer.
interface ram_slot_seq_if;
   logic       cycsel_en;
   logic       cycsel;
   logic       cpu_req;
   logic       cpu_rw;
   logic       vid_req;
   logic       ref_tick;
   logic       ras_n;
   logic       cas_n;
   logic       we_n;
   logic       addr_col;
   logic       cpu_dtack;
   logic       vid_ack;
   logic       ref_ack;
   logic [1:0] ref_pend;

   modport master (
      output cycsel_en, cycsel, cpu_req, cpu_rw,
      output vid_req, ref_tick,
      input  ras_n, cas_n, we_n, addr_col,
      input  cpu_dtack, vid_ack, ref_ack, ref_pend
   );

   modport slave (
      input  cycsel_en, cycsel, cpu_req, cpu_rw,
      input  vid_req, ref_tick,
      output ras_n, cas_n, we_n, addr_col,
      output cpu_dtack, vid_ack, ref_ack, ref_pend
   );
endinterface

// File: rtl/ram_slot_seq.sv
// ram_slot_seq: 8-clk32 DRAM slot sequencer for CPU, video and refresh.
// ACTIVE t=0..5, PRECH t=6..7; every output is a flop.
module ram_slot_seq (
   input logic           clk32,
   input logic           res,
   ram_slot_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACTIVE, PRECH} state_t;
   typedef enum logic [1:0] {G_NONE, G_CPU, G_VID, G_REF} grant_t;

   state_t     st_q, st_d;
   grant_t     gnt_q, gnt_d, pick;
   logic [2:0] t_q, t_d;
   logic       wr_q, wr_d;
   logic       ras_n_q, ras_n_d;
   logic       cas_n_q, cas_n_d;
   logic       we_n_q, we_n_d;
   logic       col_q, col_d;
   logic       dtack_q, dtack_d;
   logic       vack_q, vack_d;
   logic       rack_q, rack_d;
   logic [1:0] pend_q, pend_d;
   logic       start, act, mem, dec;

   always_comb begin
      pick = G_NONE;
      if (bus.cycsel) begin
         if (bus.cpu_req && !dtack_q) pick = G_CPU;
         else if (pend_q != 2'd0)     pick = G_REF;
      end else begin
         if (bus.vid_req)             pick = G_VID;
         else if (pend_q != 2'd0)     pick = G_REF;
      end
   end

   always_comb begin
      start = bus.cycsel_en && (st_q != ACTIVE);
      st_d  = st_q;
      t_d   = t_q;
      gnt_d = gnt_q;
      wr_d  = wr_q;
      if (start) begin
         st_d  = ACTIVE;
         t_d   = 3'd0;
         gnt_d = pick;
         wr_d  = !bus.cpu_rw;
      end else begin
         unique case (st_q)
            ACTIVE: begin
               if (t_q == 3'd5) st_d = PRECH;
               t_d = t_q + 3'd1;
            end
            PRECH: begin
               if (t_q == 3'd7) begin
                  st_d = IDLE;
                  t_d  = 3'd0;
               end else begin
                  t_d = t_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from the next state so they align with t.
   always_comb begin
      act     = (st_d == ACTIVE);
      mem     = (gnt_d == G_CPU) || (gnt_d == G_VID);
      ras_n_d = !(act && gnt_d != G_NONE);
      col_d   = act && mem && (t_d >= 3'd2);
      cas_n_d = !(act && mem && (t_d >= 3'd3));
      we_n_d  = !(act && gnt_d == G_CPU && wr_d && (t_d >= 3'd2));
      vack_d  = act && (gnt_d == G_VID) && (t_d == 3'd5);
      rack_d  = act && (gnt_d == G_REF) && (t_d == 3'd5);
   end

   always_comb begin
      if (st_q == ACTIVE && gnt_q == G_CPU && t_q == 3'd3 && bus.cpu_req)
         dtack_d = 1'b1;
      else if (!bus.cpu_req)
         dtack_d = 1'b0;
      else
         dtack_d = dtack_q;
   end

   // A tick landing on the decrement cycle cancels out.
   always_comb begin
      dec    = rack_d && (pend_q != 2'd0);
      pend_d = pend_q;
      if (bus.ref_tick && !dec && pend_q != 2'd3)
         pend_d = pend_q + 2'd1;
      else if (dec && !bus.ref_tick)
         pend_d = pend_q - 2'd1;
   end

   always_ff @(posedge clk32 or posedge res) begin
      if (res) begin
         st_q    <= IDLE;
         t_q     <= 3'd0;
         gnt_q   <= G_NONE;
         wr_q    <= 1'b0;
         ras_n_q <= 1'b1;
         cas_n_q <= 1'b1;
         we_n_q  <= 1'b1;
         col_q   <= 1'b0;
         dtack_q <= 1'b0;
         vack_q  <= 1'b0;
         rack_q  <= 1'b0;
         pend_q  <= 2'd0;
      end else begin
         st_q    <= st_d;
         t_q     <= t_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         ras_n_q <= ras_n_d;
         cas_n_q <= cas_n_d;
         we_n_q  <= we_n_d;
         col_q   <= col_d;
         dtack_q <= dtack_d;
         vack_q  <= vack_d;
         rack_q  <= rack_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.ras_n     = ras_n_q;
   assign bus.cas_n     = cas_n_q;
   assign bus.we_n      = we_n_q;
   assign bus.addr_col  = col_q;
   assign bus.cpu_dtack = dtack_q;
   assign bus.vid_ack   = vack_q;
   assign bus.ref_ack   = rack_q;
   assign bus.ref_pend  = pend_q;
endmodule

// File: tb/tb_ram_slot_seq.sv
// tb_ram_slot_seq: directed slot scenarios with hand-computed waveforms.
// Vectors hold one bit per slot cycle t=0..7 (bit t).
module tb_ram_slot_seq;
   logic clk32 = 1'b0;
   logic res;
   int   checks = 0;
   int   failures = 0;

   logic [7:0] r_ras, r_cas, r_we, r_col, r_dt, r_va, r_ra;
   logic [1:0] r_pd [8];

   ram_slot_seq_if bus ();

   ram_slot_seq dut (
      .clk32 (clk32),
      .res   (res),
      .bus   (bus)
   );

   always #5 clk32 = ~clk32;

   task automatic run_slot(input bit sel, input bit creq, input bit rw,
                           input bit vreq, input int drop_at,
                           input int tick_at, input int en_at);
      bus.cycsel_en = 1'b1;
      bus.cycsel    = sel;
      bus.cpu_req   = creq;
      bus.cpu_rw    = rw;
      bus.vid_req   = vreq;
      @(negedge clk32);
      bus.cycsel_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         r_ras[k] = bus.ras_n;
         r_cas[k] = bus.cas_n;
         r_we[k]  = bus.we_n;
         r_col[k] = bus.addr_col;
         r_dt[k]  = bus.cpu_dtack;
         r_va[k]  = bus.vid_ack;
         r_ra[k]  = bus.ref_ack;
         r_pd[k]  = bus.ref_pend;
         if (k == drop_at) bus.cpu_req = 1'b0;
         bus.ref_tick  = (k == tick_at);
         bus.cycsel_en = (k == en_at);
         @(negedge clk32);
      end
      bus.ref_tick  = 1'b0;
      bus.cycsel_en = 1'b0;
   endtask

   task automatic test_reset;
      res = 1'b1;
      bus.cycsel_en = 0; bus.cycsel = 0; bus.cpu_req = 0;
      bus.cpu_rw = 0; bus.vid_req = 0; bus.ref_tick = 0;
      repeat (3) @(negedge clk32);
      checks++;
      if ({bus.ras_n, bus.cas_n, bus.we_n} !== 3'b111) begin
         failures++;
         $display("FAIL rst_strobes got=%b exp=111",
                  {bus.ras_n, bus.cas_n, bus.we_n});
      end
      checks++;
      if ({bus.addr_col, bus.cpu_dtack, bus.vid_ack, bus.ref_ack} !== 4'b0) begin
         failures++;
         $display("FAIL rst_flags got=%b exp=0000",
                  {bus.addr_col, bus.cpu_dtack, bus.vid_ack, bus.ref_ack});
      end
      checks++;
      if (bus.ref_pend !== 2'd0) begin
         failures++;
         $display("FAIL rst_pend got=%0d exp=0", bus.ref_pend);
      end
      res = 1'b0;
      @(negedge clk32);
   endtask

   task automatic test_cpu_read;
      run_slot(1, 1, 1, 0, -1, -1, -1);
      checks++;
      if (r_ras !== 8'hC0) begin
         failures++; $display("FAIL rd_ras got=%h exp=c0", r_ras);
      end
      checks++;
      if (r_col !== 8'h3C) begin
         failures++; $display("FAIL rd_col got=%h exp=3c", r_col);
      end
      checks++;
      if (r_cas !== 8'hC7) begin
         failures++; $display("FAIL rd_cas got=%h exp=c7", r_cas);
      end
      checks++;
      if (r_we !== 8'hFF) begin
         failures++; $display("FAIL rd_we got=%h exp=ff", r_we);
      end
      checks++;
      if (r_dt !== 8'hF0) begin
         failures++; $display("FAIL rd_dtack got=%h exp=f0", r_dt);
      end
      // dtack still high: a held request must not be granted again
      run_slot(1, 1, 1, 0, -1, -1, -1);
      checks++;
      if (r_ras !== 8'hFF || r_cas !== 8'hFF) begin
         failures++;
         $display("FAIL held_none got=%h/%h exp=ff/ff", r_ras, r_cas);
      end
      checks++;
      if (r_dt !== 8'hFF) begin
         failures++; $display("FAIL held_dtack got=%h exp=ff", r_dt);
      end
      bus.cpu_req = 1'b0;
      checks++;
      if (bus.cpu_dtack !== 1'b1) begin
         failures++; $display("FAIL dtack_hold got=%b exp=1", bus.cpu_dtack);
      end
      @(negedge clk32);
      checks++;
      if (bus.cpu_dtack !== 1'b0) begin
         failures++; $display("FAIL dtack_clr got=%b exp=0", bus.cpu_dtack);
      end
   endtask

   task automatic test_write_then_video;
      run_slot(1, 1, 0, 0, 6, -1, -1);
      checks++;
      if (r_we !== 8'hC3) begin
         failures++; $display("FAIL wr_we got=%h exp=c3", r_we);
      end
      checks++;
      if (r_dt !== 8'h70) begin
         failures++; $display("FAIL wr_dtack got=%h exp=70", r_dt);
      end
      run_slot(0, 0, 1, 1, -1, -1, -1);
      bus.vid_req = 1'b0;
      checks++;
      if (r_va !== 8'h20) begin
         failures++; $display("FAIL vid_ack got=%h exp=20", r_va);
      end
      checks++;
      if (r_we !== 8'hFF) begin
         failures++; $display("FAIL vid_we got=%h exp=ff", r_we);
      end
      checks++;
      if (r_ras !== 8'hC0 || r_cas !== 8'hC7 || r_col !== 8'h3C) begin
         failures++;
         $display("FAIL vid_timing got=%h/%h/%h exp=c0/c7/3c",
                  r_ras, r_cas, r_col);
      end
   endtask

   task automatic test_refresh_backlog;
      bus.ref_tick = 1'b1;
      repeat (4) @(negedge clk32);
      bus.ref_tick = 1'b0;
      checks++;
      if (bus.ref_pend !== 2'd3) begin
         failures++; $display("FAIL pend_sat got=%0d exp=3", bus.ref_pend);
      end
      for (int i = 0; i < 3; i++) begin
         run_slot(0, 0, 1, 0, -1, -1, -1);
         checks++;
         if (r_ras !== 8'hC0 || r_cas !== 8'hFF || r_col !== 8'h00) begin
            failures++;
            $display("FAIL ref_timing%0d got=%h/%h/%h exp=c0/ff/00",
                     i, r_ras, r_cas, r_col);
         end
         checks++;
         if (r_ra !== 8'h20) begin
            failures++; $display("FAIL ref_ack%0d got=%h exp=20", i, r_ra);
         end
         checks++;
         if (r_pd[4] !== 2'(3 - i) || r_pd[7] !== 2'(2 - i)) begin
            failures++;
            $display("FAIL ref_pend%0d got=%0d,%0d exp=%0d,%0d",
                     i, r_pd[4], r_pd[7], 3 - i, 2 - i);
         end
      end
   endtask

   task automatic test_simultaneous;
      bus.ref_tick = 1'b1;
      repeat (2) @(negedge clk32);
      bus.ref_tick = 1'b0;
      run_slot(0, 0, 1, 0, -1, 4, 2);
      checks++;
      if (r_ra !== 8'h20) begin
         failures++; $display("FAIL sim_ack got=%h exp=20", r_ra);
      end
      checks++;
      if (r_pd[4] !== 2'd2 || r_pd[7] !== 2'd2) begin
         failures++;
         $display("FAIL sim_pend got=%0d,%0d exp=2,2", r_pd[4], r_pd[7]);
      end
      checks++;
      if (r_ras !== 8'hC0 || r_cas !== 8'hFF) begin
         failures++;
         $display("FAIL sim_timing got=%h/%h exp=c0/ff", r_ras, r_cas);
      end
   endtask

   task automatic test_early_drop;
      run_slot(1, 1, 1, 0, 2, -1, -1);
      checks++;
      if (r_ras !== 8'hC0 || r_cas !== 8'hC7 || r_col !== 8'h3C) begin
         failures++;
         $display("FAIL drop_timing got=%h/%h/%h exp=c0/c7/3c",
                  r_ras, r_cas, r_col);
      end
      checks++;
      if (r_dt !== 8'h00) begin
         failures++; $display("FAIL drop_dtack got=%h exp=00", r_dt);
      end
   endtask

   task automatic test_reset_mid;
      bus.cycsel_en = 1'b1; bus.cycsel = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0;
      @(negedge clk32);
      bus.cycsel_en = 1'b0;
      repeat (3) @(negedge clk32);
      checks++;
      if ({bus.ras_n, bus.cas_n, bus.we_n} !== 3'b000) begin
         failures++;
         $display("FAIL mid_pre got=%b exp=000",
                  {bus.ras_n, bus.cas_n, bus.we_n});
      end
      res = 1'b1;
      #1;
      checks++;
      if ({bus.ras_n, bus.cas_n, bus.we_n} !== 3'b111) begin
         failures++;
         $display("FAIL mid_async got=%b exp=111",
                  {bus.ras_n, bus.cas_n, bus.we_n});
      end
      checks++;
      if (bus.ref_pend !== 2'd0 || bus.cpu_dtack !== 1'b0) begin
         failures++;
         $display("FAIL mid_clear got=%0d,%b exp=0,0",
                  bus.ref_pend, bus.cpu_dtack);
      end
      repeat (2) @(negedge clk32);
      res = 1'b0;
      bus.cpu_req = 1'b0;
      run_slot(1, 1, 1, 0, 6, -1, -1);
      checks++;
      if (r_ras !== 8'hC0 || r_cas !== 8'hC7 || r_we !== 8'hFF) begin
         failures++;
         $display("FAIL post_rst got=%h/%h/%h exp=c0/c7/ff",
                  r_ras, r_cas, r_we);
      end
      checks++;
      if (r_dt !== 8'h70) begin
         failures++; $display("FAIL post_dtack got=%h exp=70", r_dt);
      end
      run_slot(0, 0, 1, 0, -1, -1, -1);
      checks++;
      if (r_ras !== 8'hFF || r_cas !== 8'hFF || r_col !== 8'h00 || r_ra !== 8'h00) begin
         failures++;
         $display("FAIL none_slot got=%h/%h/%h/%h exp=ff/ff/00/00",
                  r_ras, r_cas, r_col, r_ra);
      end
   endtask

   initial begin
      test_reset;
      test_cpu_read;
      test_write_then_video;
      test_refresh_backlog;
      test_simultaneous;
      test_early_drop;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
